// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//  Turns the raw PS/2 scancode byte stream into make/break key events. The
//  E0 (extended) and F0 (break) prefixes are stripped, typematic repeats of
//  the held key are suppressed, distinct presses are counted, and events are
//  queued in a FIFO that the consumer pops with a valid/ready handshake.
// Ports
//  clk, rst        system clock, synchronous active-high reset
//  in_valid/data   one-cycle strobe carrying a received scancode byte
//  ev_valid/ready  FIFO head present / consumer pops the head
//  ev_code/ext/brk head event fields, forced to 0 while the FIFO is empty
//  held/held_code  currently held key as {ext, code}
//  press_count     accepted make events since reset (wraps)
//  fifo_level      entries queued
//  overflow        sticky: an event was dropped on a full FIFO
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen
// S_BRK     | F0 seen
// S_EXT_BRK | E0 F0 seen
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_break,
   output logic             held,
   output logic [8:0]       held_code,
   output logic [CNT_W-1:0] press_count,
   output logic [AW:0]      fifo_level,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

   state_t       state, state_nxt;
   logic         is_make, is_brk, is_ext;
   logic         is_prefix;
   logic [8:0]   key;
   logic         repeat_hit, do_make, push, pop, full, push_ok;
   logic [9:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [9:0]   head;

   assign is_prefix = (in_data == 8'hE0) || (in_data == 8'hF0);

   always_comb begin
      state_nxt = state;
      is_make   = 1'b0;
      is_brk    = 1'b0;
      is_ext    = 1'b0;
      if (in_valid) begin
         if (in_data == 8'h00 || in_data == 8'hFF) begin
            state_nxt = S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (in_data == 8'hE0)      state_nxt = S_EXT;
                  else if (in_data == 8'hF0) state_nxt = S_BRK;
                  else                       is_make   = 1'b1;
               end
               S_EXT: begin
                  if (in_data == 8'hF0)      state_nxt = S_EXT_BRK;
                  else if (in_data == 8'hE0) state_nxt = S_EXT;
                  else begin
                     is_make   = 1'b1;
                     is_ext    = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end
               S_BRK: begin
                  state_nxt = S_IDLE;
                  is_brk    = !is_prefix;
               end
               S_EXT_BRK: begin
                  state_nxt = S_IDLE;
                  is_brk    = !is_prefix;
                  is_ext    = 1'b1;
               end
               default: state_nxt = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   assign key        = {is_ext, in_data};
   assign repeat_hit = held && (key == held_code);
   assign do_make    = is_make && !repeat_hit;
   assign push       = do_make || is_brk;
   assign pop        = ev_valid && ev_ready;
   assign full       = (fifo_level == FULL_LVL);
   // When full, a simultaneous pop frees the slot being written this cycle.
   assign push_ok    = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         held        <= 1'b0;
         held_code   <= 9'h000;
         press_count <= '0;
         fifo_level  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         overflow    <= 1'b0;
      end else begin
         if (do_make) begin
            press_count <= press_count + CNT_W'(1);
            held        <= 1'b1;
            held_code   <= key;
         end else if (is_brk && repeat_hit) begin
            held <= 1'b0;
         end
         if (push && !push_ok) overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {is_brk, is_ext, in_data};
   end

   assign head     = mem[rd_ptr];
   assign ev_valid = (fifo_level != '0);
   assign ev_code  = ev_valid ? head[7:0] : 8'h00;
   assign ev_ext   = ev_valid ? head[8]   : 1'b0;
   assign ev_break = ev_valid ? head[9]   : 1'b0;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       held;
   logic [8:0] held_code;
   logic [7:0] press_count;
   logic [3:0] fifo_level;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   ps2_key_event_ctrl #(.FIFO_DEPTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .held(held),
      .held_code(held_code), .press_count(press_count),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] b;
      logic       held;
      logic [8:0] hc;
      logic [7:0] cnt;
      logic [3:0] lvl;
   } vec_t;

   vec_t       vec [0:20];
   logic [9:0] evx [0:7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      ev_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // caller is at a negedge; checks the head then pops it
   task automatic pop_chk(input string name, input logic [9:0] exp);
      chk({name, "_valid"}, ev_valid, 1);
      chk(name, {ev_break, ev_ext, ev_code}, exp);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   initial begin
      //            byte   held  held_code cnt  lvl
      vec[0]  = '{8'h1C, 1'b1, 9'h01C, 8'd1, 4'd1};
      vec[1]  = '{8'h1C, 1'b1, 9'h01C, 8'd1, 4'd1};
      vec[2]  = '{8'hF0, 1'b1, 9'h01C, 8'd1, 4'd1};
      vec[3]  = '{8'h1C, 1'b0, 9'h01C, 8'd1, 4'd2};
      vec[4]  = '{8'hE0, 1'b0, 9'h01C, 8'd1, 4'd2};
      vec[5]  = '{8'h75, 1'b1, 9'h175, 8'd2, 4'd3};
      vec[6]  = '{8'h75, 1'b1, 9'h075, 8'd3, 4'd4};
      vec[7]  = '{8'hE0, 1'b1, 9'h075, 8'd3, 4'd4};
      vec[8]  = '{8'hF0, 1'b1, 9'h075, 8'd3, 4'd4};
      vec[9]  = '{8'h75, 1'b1, 9'h075, 8'd3, 4'd5};
      vec[10] = '{8'hF0, 1'b1, 9'h075, 8'd3, 4'd5};
      vec[11] = '{8'h75, 1'b0, 9'h075, 8'd3, 4'd6};
      vec[12] = '{8'hF0, 1'b0, 9'h075, 8'd3, 4'd6};
      vec[13] = '{8'hE0, 1'b0, 9'h075, 8'd3, 4'd6};
      vec[14] = '{8'h32, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[15] = '{8'hE0, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[16] = '{8'hFF, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[17] = '{8'h32, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[18] = '{8'hE0, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[19] = '{8'hE0, 1'b1, 9'h032, 8'd4, 4'd7};
      vec[20] = '{8'h6B, 1'b1, 9'h16B, 8'd5, 4'd8};
      // expected queue contents {break, ext, code}
      evx[0] = {2'b00, 8'h1C};
      evx[1] = {2'b10, 8'h1C};
      evx[2] = {2'b01, 8'h75};
      evx[3] = {2'b00, 8'h75};
      evx[4] = {2'b11, 8'h75};
      evx[5] = {2'b10, 8'h75};
      evx[6] = {2'b00, 8'h32};
      evx[7] = {2'b01, 8'h6B};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_valid", ev_valid, 0);
      chk("rst_head", {ev_break, ev_ext, ev_code}, 0);
      chk("rst_held", {held, held_code}, 0);
      chk("rst_cnt", press_count, 0);
      chk("rst_lvl", fifo_level, 0);
      chk("rst_ovf", overflow, 0);

      // table: parser, typematic, held tracking, queue depth
      for (int i = 0; i <= 20; i++) begin
         send_byte(vec[i].b);
         chk($sformatf("vec%0d_held", i), held, vec[i].held);
         chk($sformatf("vec%0d_hc", i), held_code, vec[i].hc);
         chk($sformatf("vec%0d_cnt", i), press_count, vec[i].cnt);
         chk($sformatf("vec%0d_lvl", i), fifo_level, vec[i].lvl);
      end
      chk("tbl_ovf", overflow, 0);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("tbl_ev%0d", i), evx[i]);
      chk("tbl_empty", ev_valid, 0);
      chk("tbl_empty_head", {ev_break, ev_ext, ev_code}, 0);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      chk("pop_empty_lvl", fifo_level, 0);

      // overflow: 9 distinct makes into 8 entries
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
      chk("ovf_lvl", fifo_level, 8);
      chk("ovf_flag", overflow, 1);
      chk("ovf_cnt", press_count, 9);
      repeat (3) @(negedge clk);
      chk("ovf_hold_head", {ev_break, ev_ext, ev_code}, {2'b00, 8'h10});
      for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_ev%0d", i), {2'b00, 8'h10 + 8'(i)});
      chk("ovf_empty", ev_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // push and pop together while full
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
      chk("pp_full", fifo_level, 8);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h28; ev_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; ev_ready = 1'b0;
      chk("pp_lvl", fifo_level, 8);
      chk("pp_ovf", overflow, 0);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("pp_ev%0d", i), {2'b00, 8'h21 + 8'(i)});
      chk("pp_empty", ev_valid, 0);

      // reset discards a pending prefix; FF error byte is discarded
      do_reset();
      send_byte(8'hE0);
      do_reset();
      send_byte(8'h1C);
      chk("r6_lvl", fifo_level, 1);
      chk("r6_head", {ev_break, ev_ext, ev_code}, {2'b00, 8'h1C});
      send_byte(8'hF0);
      send_byte(8'hFF);
      send_byte(8'h2A);
      chk("ff_lvl", fifo_level, 2);
      chk("ff_held", {held, held_code}, {1'b1, 9'h02A});
      pop_chk("ff_ev0", {2'b00, 8'h1C});
      pop_chk("ff_ev1", {2'b00, 8'h2A});

      // press counter wraps after 256 presses
      do_reset();
      ev_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h1C);
         send_byte(8'hF0);
         send_byte(8'h1C);
         if (i == 254) chk("wrap_255", press_count, 255);
      end
      chk("wrap_0", press_count, 0);
      chk("wrap_held", held, 0);
      chk("wrap_ovf", overflow, 0);
      @(negedge clk);
      chk("wrap_empty", fifo_level, 0);
      ev_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
